// File: rtl/cpu_tick_pkg.sv
// Shared types and constants for the CPU tick controller: FSM state encoding,
// mode_sel decode values and the tick counter width.
package cpu_tick_pkg;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_BRK  = 2'd3
    } state_e;

    localparam logic [1:0] MODE_HALT = 2'b00;
    localparam logic [1:0] MODE_RUN  = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;

    localparam int unsigned TICK_CNT_W = 16;
    localparam logic [TICK_CNT_W-1:0] TICK_INC = 16'd1;

    // The reserved encoding 11 is folded into HALT.
    function automatic state_e decode_mode(input logic [1:0] mode);
        case (mode)
            MODE_RUN:  decode_mode = ST_RUN;
            MODE_STEP: decode_mode = ST_STEP;
            MODE_HALT: decode_mode = ST_HALT;
            default:   decode_mode = ST_HALT;
        endcase
    endfunction

endpackage

// File: rtl/cpu_tick_controller_counter.sv
// Period counter for free-run mode: counts 0..period-1 while enabled and
// flags the wrap cycle; clear has priority over counting.
module tick_period_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [CNT_W-1:0] period_i,
    output logic             wrap_o
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign wrap_o = enable_i && (count_q == (period_i - ONE));

    // Next count: clear, wrap to zero, or increment.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            if (wrap_o) begin
                count_d = '0;
            end else begin
                count_d = count_q + ONE;
            end
        end else begin
            count_d = count_q;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cpu_tick_controller.sv
// Generates the core's one-cycle tick enable: mode FSM (halt/run/step/break),
// step-button edge detect and a programmable period with deferred updates.
module cpu_tick_controller
    import cpu_tick_pkg::*;
#(
    parameter int unsigned      CNT_W       = 32,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = 32'd25_000_000,
    parameter logic [CNT_W-1:0] MIN_DIV     = 32'd2
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic [1:0]            mode_sel,
    input  logic                  step_req,
    input  logic                  halt_req,
    input  logic                  div_wr,
    input  logic [CNT_W-1:0]      div_data,
    output logic                  div_ack,
    output logic                  tick,
    output logic [TICK_CNT_W-1:0] tick_count,
    output state_e                state
);

    function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
        if (d < MIN_DIV) begin
            clamp_div = MIN_DIV;
        end else begin
            clamp_div = d;
        end
    endfunction

    state_e                state_q, state_d;
    logic                  tick_q, tick_d;
    logic                  ack_q, ack_d;
    logic [TICK_CNT_W-1:0] tick_count_q, tick_count_d;
    logic [CNT_W-1:0]      div_active_q, div_active_d;
    logic [CNT_W-1:0]      div_pending_q, div_pending_d;
    logic                  pend_q, pend_d;
    logic                  step_q, step_prev_q;
    logic                  wrap_s, apply_s, run_stay_s, step_edge_s;

    tick_period_counter #(.CNT_W(CNT_W)) u_counter (
        .clk_in   (clk_in),
        .reset    (reset),
        .clear_i  (state_d != ST_RUN),
        .enable_i (state_q == ST_RUN),
        .period_i (div_active_q),
        .wrap_o   (wrap_s)
    );

    // Next-state, tick and divisor-update decisions.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HALT, ST_STEP: state_d = decode_mode(mode_sel);
            ST_RUN: begin
                if (halt_req) begin
                    state_d = ST_BRK;
                end else begin
                    state_d = decode_mode(mode_sel);
                end
            end
            ST_BRK: begin
                if (mode_sel != MODE_RUN) begin
                    state_d = decode_mode(mode_sel);
                end else begin
                    state_d = ST_BRK;
                end
            end
            default: state_d = ST_HALT;
        endcase

        run_stay_s  = (state_q == ST_RUN) && (state_d == ST_RUN);
        step_edge_s = step_q && !step_prev_q;

        // A wrap only produces a tick if the FSM stays in RUN across it.
        if (run_stay_s) begin
            tick_d = wrap_s;
        end else if (state_q == ST_STEP) begin
            tick_d = step_edge_s;
        end else begin
            tick_d = 1'b0;
        end

        if (state_q == ST_RUN) begin
            apply_s = pend_q && wrap_s;
        end else begin
            apply_s = pend_q;
        end

        // A write in the same cycle as an apply re-arms pending with the new value.
        pend_d        = pend_q;
        div_pending_d = div_pending_q;
        if (div_wr) begin
            pend_d        = 1'b1;
            div_pending_d = clamp_div(div_data);
        end else if (apply_s) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end

        if (apply_s) begin
            div_active_d = div_pending_q;
        end else begin
            div_active_d = div_active_q;
        end
        ack_d = apply_s;

        if (tick_d) begin
            tick_count_d = tick_count_q + TICK_INC;
        end else begin
            tick_count_d = tick_count_q;
        end
    end

    // FSM state and all registered outputs.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q       <= ST_HALT;
            tick_q        <= 1'b0;
            ack_q         <= 1'b0;
            tick_count_q  <= '0;
            div_active_q  <= DEFAULT_DIV;
            div_pending_q <= DEFAULT_DIV;
            pend_q        <= 1'b0;
            step_q        <= 1'b0;
            step_prev_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_q        <= tick_d;
            ack_q         <= ack_d;
            tick_count_q  <= tick_count_d;
            div_active_q  <= div_active_d;
            div_pending_q <= div_pending_d;
            pend_q        <= pend_d;
            step_q        <= step_req;
            step_prev_q   <= step_q;
        end
    end

    assign tick       = tick_q;
    assign div_ack    = ack_q;
    assign tick_count = tick_count_q;
    assign state      = state_q;

endmodule

// File: tb/tb_cpu_tick_controller.sv
// Scoreboard bench for cpu_tick_controller: stimulus queues expected tick and
// ack events by cycle, a negedge monitor pops and compares them.
module tb_cpu_tick_controller;
    import cpu_tick_pkg::*;

    logic                  clk_in = 1'b0;
    logic                  reset;
    logic [1:0]            mode_sel;
    logic                  step_req;
    logic                  halt_req;
    logic                  div_wr;
    logic [31:0]           div_data;
    logic                  div_ack;
    logic                  tick;
    logic [TICK_CNT_W-1:0] tick_count;
    state_e                state;

    cpu_tick_controller #(
        .CNT_W       (32),
        .DEFAULT_DIV (32'd4),
        .MIN_DIV     (32'd2)
    ) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .mode_sel   (mode_sel),
        .step_req   (step_req),
        .halt_req   (halt_req),
        .div_wr     (div_wr),
        .div_data   (div_data),
        .div_ack    (div_ack),
        .tick       (tick),
        .tick_count (tick_count),
        .state      (state)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        int          at;
        logic [15:0] cnt;
    } tick_exp_t;

    tick_exp_t   tick_exp[$];
    int          ack_exp[$];
    logic [15:0] exp_cnt = 16'd0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compare every presented tick/ack against the head of its queue.
    always @(negedge clk_in) begin
        tick_exp_t e;
        int        a;
        if (cyc > 0) begin
            while (tick_exp.size() > 0 && tick_exp[0].at < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL missed_tick: no tick, expected at cycle %0d", tick_exp[0].at);
                void'(tick_exp.pop_front());
            end
            while (ack_exp.size() > 0 && ack_exp[0] < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL missed_ack: no div_ack, expected at cycle %0d", ack_exp[0]);
                void'(ack_exp.pop_front());
            end
            if (tick !== 1'b0) begin
                if (tick_exp.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_tick: tick=%b at cycle %0d, expected none", tick, cyc);
                end else begin
                    e = tick_exp.pop_front();
                    chk("tick_cycle", cyc, e.at);
                    chk("tick_count", {16'd0, tick_count}, {16'd0, e.cnt});
                end
            end
            if (div_ack !== 1'b0) begin
                if (ack_exp.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_ack: div_ack=%b at cycle %0d, expected none", div_ack, cyc);
                end else begin
                    a = ack_exp.pop_front();
                    chk("ack_cycle", cyc, a);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step(1);
    endtask

    task automatic exp_tick(input int at);
        exp_cnt = exp_cnt + 16'd1;
        tick_exp.push_back('{at, exp_cnt});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int e;
        reset = 1'b1; mode_sel = MODE_HALT; step_req = 1'b0; halt_req = 1'b0;
        div_wr = 1'b0; div_data = 32'd0;
        step(3);
        reset = 1'b0;
        chk("rst_state", {30'd0, state}, {30'd0, ST_HALT});
        chk("rst_tick", {31'd0, tick}, 32'd0);
        chk("rst_ack", {31'd0, div_ack}, 32'd0);
        chk("rst_tick_count", {16'd0, tick_count}, 32'd0);
        step(2);

        // Free run with the default period of 4; leaving at a wrap drops that tick.
        mode_sel = MODE_RUN; k = cyc + 1;
        exp_tick(k + 4); exp_tick(k + 8); exp_tick(k + 12);
        step(1);
        chk("run_state", {30'd0, state}, {30'd0, ST_RUN});
        wait_until(k + 12);
        chk("tick_count_12", {16'd0, tick_count}, 32'd3);
        wait_until(k + 15);
        mode_sel = MODE_HALT;
        step(1);
        chk("exit_at_wrap_state", {30'd0, state}, {30'd0, ST_HALT});
        step(2);

        // Step edges outside STEP are ignored.
        step_req = 1'b1; step(3); step_req = 1'b0; step(2);

        // Single-step: held button gives one tick, a second press gives another.
        mode_sel = MODE_STEP; step(2);
        chk("step_state", {30'd0, state}, {30'd0, ST_STEP});
        step_req = 1'b1; e = cyc; exp_tick(e + 2);
        step(10);
        step_req = 1'b0; step(3);
        step_req = 1'b1; e = cyc; exp_tick(e + 2);
        step(4);
        step_req = 1'b0; mode_sel = MODE_HALT; step(2);

        // Period change in RUN applies at the next wrap; a value of 1 clamps to 2.
        mode_sel = MODE_RUN; k = cyc + 1;
        exp_tick(k + 4);
        wait_until(k + 5);
        div_wr = 1'b1; div_data = 32'd6; step(1); div_wr = 1'b0;
        exp_tick(k + 8); ack_exp.push_back(k + 8); exp_tick(k + 14); exp_tick(k + 20);
        wait_until(k + 21);
        div_wr = 1'b1; div_data = 32'd1; step(1); div_wr = 1'b0;
        exp_tick(k + 26); ack_exp.push_back(k + 26); exp_tick(k + 28); exp_tick(k + 30);
        wait_until(k + 30);
        mode_sel = MODE_HALT; step(2);

        // Back to period 4 while halted: ack one cycle after capture.
        div_wr = 1'b1; div_data = 32'd4; e = cyc; step(1); div_wr = 1'b0;
        ack_exp.push_back(e + 2);
        step(3);

        // Breakpoint at a wrap suppresses the tick and holds until RUN is deselected.
        mode_sel = MODE_RUN; k = cyc + 1;
        exp_tick(k + 4);
        wait_until(k + 7);
        halt_req = 1'b1; step(1); halt_req = 1'b0;
        chk("brk_state", {30'd0, state}, {30'd0, ST_BRK});
        step(3);
        chk("brk_hold", {30'd0, state}, {30'd0, ST_BRK});
        mode_sel = MODE_HALT; step(1);
        chk("brk_exit", {30'd0, state}, {30'd0, ST_HALT});
        mode_sel = MODE_RUN; k = cyc + 1;
        exp_tick(k + 4);
        wait_until(k + 4);
        mode_sel = MODE_HALT; step(2);

        // Two writes while halted, one cycle apart: two acks, final period 7.
        div_wr = 1'b1; div_data = 32'd5; e = cyc; step(1);
        div_data = 32'd7; step(1); div_wr = 1'b0;
        ack_exp.push_back(e + 2); ack_exp.push_back(e + 3);
        step(2);
        mode_sel = MODE_RUN; k = cyc + 1;
        exp_tick(k + 7);
        wait_until(k + 7);
        mode_sel = MODE_HALT; step(2);
        div_wr = 1'b1; div_data = 32'd4; e = cyc; step(1); div_wr = 1'b0;
        ack_exp.push_back(e + 2);
        step(3);

        // Same two writes inside one RUN period: last wins, single ack.
        mode_sel = MODE_RUN; k = cyc + 1;
        exp_tick(k + 4);
        wait_until(k + 4);
        div_wr = 1'b1; div_data = 32'd5; step(1);
        div_data = 32'd7; step(1); div_wr = 1'b0;
        exp_tick(k + 8); ack_exp.push_back(k + 8); exp_tick(k + 15);
        wait_until(k + 16);
        div_wr = 1'b1; div_data = 32'd3; step(1); div_wr = 1'b0;
        step(1);

        // Reset mid-period with a divisor pending: everything returns to defaults.
        reset = 1'b1; mode_sel = MODE_HALT; step(1);
        exp_cnt = 16'd0;
        chk("midrst_state", {30'd0, state}, {30'd0, ST_HALT});
        chk("midrst_tick", {31'd0, tick}, 32'd0);
        chk("midrst_ack", {31'd0, div_ack}, 32'd0);
        chk("midrst_tick_count", {16'd0, tick_count}, 32'd0);
        reset = 1'b0; step(1);
        mode_sel = MODE_RUN; k = cyc + 1;
        exp_tick(k + 4); exp_tick(k + 8);
        wait_until(k + 8);
        mode_sel = MODE_HALT; step(3);

        chk("tick_queue_empty", tick_exp.size(), 32'd0);
        chk("ack_queue_empty", ack_exp.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
